// File: rtl/hsi_m_rx_ctrl.sv
// hsi_m_rx_ctrl: master-side HSI reply framer with CRC16-CCITT check and first-byte/inter-byte timeouts
module hsi_m_rx_ctrl #(
  parameter int SR_LEN = 9,
  parameter int DPR_LEN = 4,
  parameter int CCW_LEN = 2,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int GAP_TICKS = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd_wait,
  input  logic [7:0] dec_d,
  input  logic       dec_d_rdy,
  output logic [7:0] rx_d,
  output logic       rx_d_wr,
  output logic [2:0] rx_type,
  output logic       rx_busy,
  output logic       rx_msg_ok,
  output logic       rx_crc_err,
  output logic       rx_timeout,
  output logic       rx_unsolicited
);
  localparam logic [15:0] FIRST_TC = 16'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] GAP_TC = 16'(GAP_TICKS - 1);
  typedef enum logic [2:0] {IDLE, WAIT_FIRST, PAYLOAD, CRC_HI, CRC_LO} state_t;
  state_t state;
  logic [2:0] cmd_prev;
  logic [15:0] tick, crc, crc_next;
  logic [7:0] cnt, len, crc_msb;
  logic arm, tc;
  always_comb begin
    crc_next = crc ^ {dec_d, 8'h00};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[15] ? {crc_next[14:0], 1'b0} ^ 16'h1021 : {crc_next[14:0], 1'b0};
  end
  assign arm = cmd_prev == 3'b000 && $onehot(cmd_wait);
  assign tc = tick == (state == WAIT_FIRST ? FIRST_TC : GAP_TC);
  assign rx_busy = state != IDLE;
  // a byte strobe always beats a terminal count on the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cmd_prev <= '0;
      tick <= '0;
      cnt <= '0;
      len <= '0;
      crc <= 16'hFFFF;
      crc_msb <= '0;
      rx_d <= '0;
      rx_d_wr <= 1'b0;
      rx_type <= '0;
      rx_msg_ok <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_timeout <= 1'b0;
      rx_unsolicited <= 1'b0;
    end else begin
      cmd_prev <= cmd_wait;
      rx_d_wr <= 1'b0;
      rx_msg_ok <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_timeout <= 1'b0;
      rx_unsolicited <= state == IDLE && dec_d_rdy;
      tick <= &tick ? tick : tick + 16'd1;
      if (state == IDLE) begin
        tick <= '0;
        if (arm) begin
          rx_type <= cmd_wait;
          len <= cmd_wait[0] ? 8'(SR_LEN) : cmd_wait[1] ? 8'(DPR_LEN) : 8'(CCW_LEN);
          cnt <= '0;
          crc <= 16'hFFFF;
          state <= WAIT_FIRST;
        end
      end else if (dec_d_rdy) begin
        tick <= '0;
        if (state == CRC_HI) begin
          crc_msb <= dec_d;
          state <= CRC_LO;
        end else if (state == CRC_LO) begin
          rx_msg_ok <= {crc_msb, dec_d} == crc;
          rx_crc_err <= {crc_msb, dec_d} != crc;
          state <= IDLE;
        end else begin
          crc <= crc_next;
          rx_d <= dec_d;
          rx_d_wr <= 1'b1;
          cnt <= cnt + 8'd1;
          state <= cnt + 8'd1 == len ? CRC_HI : PAYLOAD;
        end
      end else if (tc) begin
        rx_timeout <= 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_hsi_m_rx_ctrl.sv
// tb_hsi_m_rx_ctrl: randomized replies checked against a bit-serial CRC model and spec timing rules
module tb_hsi_m_rx_ctrl;
  localparam int SR = 9, DPR = 4, CCW = 2, TO = 50, GAP = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cmd_wait = '0;
  logic [7:0] dec_d = '0;
  logic dec_d_rdy = 1'b0;
  logic [7:0] rx_d;
  logic [2:0] rx_type;
  logic rx_d_wr, rx_busy, rx_msg_ok, rx_crc_err, rx_timeout, rx_unsolicited;
  int n_chk = 0, n_err = 0, n_ok = 0, n_bad = 0, n_to = 0, n_unsol = 0, cyc = 0, to_cyc = 0;
  logic [7:0] wr_q[$], pl[$];

  hsi_m_rx_ctrl #(.SR_LEN(SR), .DPR_LEN(DPR), .CCW_LEN(CCW), .TIMEOUT_TICKS(TO), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_wait(cmd_wait), .dec_d(dec_d), .dec_d_rdy(dec_d_rdy),
    .rx_d(rx_d), .rx_d_wr(rx_d_wr), .rx_type(rx_type), .rx_busy(rx_busy), .rx_msg_ok(rx_msg_ok),
    .rx_crc_err(rx_crc_err), .rx_timeout(rx_timeout), .rx_unsolicited(rx_unsolicited)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (rx_d_wr) wr_q.push_back(rx_d);
      if (rx_msg_ok) n_ok++;
      if (rx_crc_err) n_bad++;
      if (rx_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
      if (rx_unsolicited) n_unsol++;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    n_ok = 0;
    n_bad = 0;
    n_to = 0;
    n_unsol = 0;
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (pl[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ pl[i][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  function automatic int len_of(input logic [2:0] t);
    return t[0] ? SR : t[1] ? DPR : CCW;
  endfunction

  task automatic fill(input logic [2:0] t);
    pl.delete();
    repeat (len_of(t)) pl.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pay);
    @(negedge clk);
    dec_d = b;
    dec_d_rdy = 1'b1;
    @(negedge clk);
    dec_d_rdy = 1'b0;
    dec_d = 8'($urandom);
    if (pay) check("wr_latency", 32'({rx_d_wr, rx_d}), 32'({1'b1, b}));
  endtask

  task automatic arm(input logic [2:0] t, input bit hold);
    @(negedge clk);
    cmd_wait = t;
    @(negedge clk);
    if (!hold) cmd_wait = '0;
    check("busy_rise", 32'(rx_busy), 1);
  endtask

  task automatic wait_to(input int lim);
    int k = 0;
    while (n_to == 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic reply(input logic [2:0] t, input logic [15:0] c, input bit exp_ok, input bit hold);
    clear_mon();
    arm(t, hold);
    foreach (pl[i]) begin
      send_byte(pl[i], 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    send_byte(c[15:8], 1'b0);
    send_byte(c[7:0], 1'b0);
    check("verdict_latency", 32'({rx_msg_ok, rx_crc_err}), 32'({exp_ok, !exp_ok}));
    check("busy_fall", 32'(rx_busy), 0);
    repeat (3) @(negedge clk);
    check("no_rearm", 32'(rx_busy), 0);
    cmd_wait = '0;
    check("n_wr", wr_q.size(), pl.size());
    foreach (pl[i]) if (i < wr_q.size()) check("rx_d", 32'(wr_q[i]), 32'(pl[i]));
    check("n_ok", n_ok, 32'(exp_ok));
    check("n_crc_err", n_bad, 32'(!exp_ok));
    check("n_timeout", n_to, 0);
    check("rx_type", 32'(rx_type), 32'(t));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0] t;
    logic [15:0] c;
    bit bad;
    int t0, s;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({rx_d, rx_d_wr, rx_type, rx_busy, rx_msg_ok, rx_crc_err, rx_timeout, rx_unsolicited}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // SR OK with the arm level held through the reply, then the same reply with a bad LSB
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    reply(3'b001, 16'h29B1, 1'b1, 1'b1);
    reply(3'b001, 16'h29B0, 1'b0, 1'b0);
    // first-byte timeout
    clear_mon();
    @(negedge clk);
    cmd_wait = 3'b010;
    t0 = cyc;
    @(negedge clk);
    cmd_wait = '0;
    wait_to(200);
    check("first_to_cycles", to_cyc - t0, TO + 1);
    check("first_to_busy", 32'(rx_busy), 0);
    repeat (3) @(negedge clk);
    check("first_to_count", n_to, 1);
    check("first_to_type", 32'(rx_type), 32'(3'b010));
    // inter-byte timeout after one CCW byte
    clear_mon();
    arm(3'b100, 1'b0);
    send_byte(8'h5A, 1'b1);
    s = cyc;
    wait_to(100);
    check("gap_to_cycles", to_cyc - s, GAP);
    check("gap_to_writes", wr_q.size(), 1);
    check("gap_to_verdicts", n_ok + n_bad, 0);
    // second byte lands on the terminal-count cycle; an arm edge mid-reply is ignored
    pl.delete();
    pl.push_back(8'hC3);
    pl.push_back(8'h3C);
    c = crc_ref();
    clear_mon();
    arm(3'b100, 1'b0);
    send_byte(pl[0], 1'b1);
    @(negedge clk);
    cmd_wait = 3'b001;
    @(negedge clk);
    cmd_wait = '0;
    repeat (16) @(negedge clk);
    send_byte(pl[1], 1'b1);
    send_byte(c[15:8], 1'b0);
    send_byte(c[7:0], 1'b0);
    repeat (2) @(negedge clk);
    check("tie_ok", n_ok, 1);
    check("tie_timeout", n_to, 0);
    check("tie_type", 32'(rx_type), 32'(3'b100));
    check("tie_busy", 32'(rx_busy), 0);
    // unsolicited byte and illegal multi-bit arm
    clear_mon();
    send_byte(8'hA5, 1'b0);
    check("unsol_latency", 32'(rx_unsolicited), 1);
    repeat (2) @(negedge clk);
    check("unsol_count", n_unsol, 1);
    check("unsol_writes", wr_q.size(), 0);
    cmd_wait = 3'b011;
    repeat (4) @(negedge clk);
    check("illegal_arm", 32'(rx_busy), 0);
    cmd_wait = '0;
    // reset mid-reply
    fill(3'b001);
    clear_mon();
    arm(3'b001, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(pl[i], 1'b1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 32'({rx_d, rx_d_wr, rx_type, rx_busy, rx_msg_ok, rx_crc_err, rx_timeout, rx_unsolicited}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (GAP + 5) @(negedge clk);
    check("mid_reset_verdicts", n_ok + n_bad + n_to, 0);
    fill(3'b001);
    reply(3'b001, crc_ref(), 1'b1, 1'b0);
    // randomized replies
    for (int k = 0; k < 20; k++) begin
      t = 3'(3'b001 << $urandom_range(0, 2));
      fill(t);
      c = crc_ref();
      bad = $urandom_range(0, 2) == 0;
      if (bad) c = c ^ (16'd1 << $urandom_range(0, 15));
      reply(t, c, !bad, 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
